// File: rtl/cam_pix_capture_param_if.sv
// Capture-engine bus: sensor DVP inputs, config level, and frame-RAM write side.
// master = capture engine, slave = sensor/RAM environment.
interface cam_pix_capture_param_if #(
    parameter int ADDR_W = 19,
    parameter int PIX_W  = 12
);
    logic              config_done;
    logic              href;
    logic              vsync;
    logic [7:0]        data_in;
    logic              data_en;
    logic [PIX_W-1:0]  rgb_data;
    logic [ADDR_W-1:0] RAM_addr;
    logic              frame_done;
    logic              ovf_err;

    modport master (
        input  config_done, href, vsync, data_in,
        output data_en, rgb_data, RAM_addr, frame_done, ovf_err
    );

    modport slave (
        output config_done, href, vsync, data_in,
        input  data_en, rgb_data, RAM_addr, frame_done, ovf_err
    );
endinterface

// File: rtl/cam_pix_capture_param.sv
// DVP pixel capture: RGB565 byte-pair assembly, RGB444/565 output, linear write address, frame skip.
// Optional macro CAP_DECIM_2X_EN: keep only even-x/even-y pixels (half stride).
module cam_pix_capture_param #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int ADDR_W     = 19,
    parameter int PIX_W      = 12,
    parameter int FRAME_SKIP = 0,
    parameter int HI_FIRST   = 1
) (
    input  logic                      pclk,
    input  logic                      rst,
    cam_pix_capture_param_if.master   bus
);

    localparam int X_W = $clog2(H_ACTIVE) + 1;
    localparam int Y_W = $clog2(V_ACTIVE) + 1;
    localparam int S_W = (FRAME_SKIP > 0) ? $clog2(FRAME_SKIP + 1) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT_VS = 2'd1;
    localparam logic [1:0] ST_ACTIVE  = 2'd2;
    localparam logic [1:0] ST_SKIP    = 2'd3;

    // Reduce assembled RGB565 to the configured output width.
    function automatic logic [PIX_W-1:0] fmt_pix(input logic [15:0] p);
        logic [15:0] t;
        if (PIX_W == 16) begin
            t = p;
        end else begin
            t = {4'h0, p[15:12], p[10:7], p[4:1]};
        end
        return t[PIX_W-1:0];
    endfunction

    logic              href_r;
    logic              vsync_r;
    logic [7:0]        data_r;
    logic              href_d_r;
    logic              vsync_d_r;
    logic [1:0]        state_r;
    logic [S_W-1:0]    skip_cnt_r;
    logic              phase_r;
    logic [7:0]        byte0_r;
    logic [X_W-1:0]    x_r;
    logic [Y_W-1:0]    y_r;
    logic              line_pix_r;
    logic [ADDR_W-1:0] addr_r;
    logic              wr_pend_r;
    logic [PIX_W-1:0]  pix_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic              data_en_r;
    logic [PIX_W-1:0]  rgb_data_r;
    logic [ADDR_W-1:0] ram_addr_r;
    logic              frame_done_r;
    logic              ovf_err_r;

    logic              vs_fall_s;
    logic              vs_rise_s;
    logic              vs_edge_s;
    logic              href_fall_s;
    logic              in_frame_s;
    logic              take_s;
    logic              pair_s;
    logic              in_bounds_s;
    logic              keep_s;
    logic [15:0]       pix565_s;

    // Single register stage on all sensor pins; everything downstream uses these copies.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            href_r    <= 1'b0;
            vsync_r   <= 1'b0;
            data_r    <= 8'h00;
            href_d_r  <= 1'b0;
            vsync_d_r <= 1'b0;
        end else begin
            href_r    <= bus.href;
            vsync_r   <= bus.vsync;
            data_r    <= bus.data_in;
            href_d_r  <= href_r;
            vsync_d_r <= vsync_r;
        end
    end

    // Edge detection and per-byte decode.
    always_comb begin
        vs_fall_s   = vsync_d_r & ~vsync_r;
        vs_rise_s   = ~vsync_d_r & vsync_r;
        vs_edge_s   = vs_fall_s | vs_rise_s;
        href_fall_s = href_d_r & ~href_r;
        in_frame_s  = bus.config_done & ((state_r == ST_ACTIVE) | (state_r == ST_SKIP));
        take_s      = in_frame_s & href_r & ~vs_edge_s;
        pair_s      = take_s & phase_r;
        in_bounds_s = (x_r < X_W'(H_ACTIVE)) && (y_r < Y_W'(V_ACTIVE));
        if (HI_FIRST != 0) begin
            pix565_s = {byte0_r, data_r};
        end else begin
            pix565_s = {data_r, byte0_r};
        end
`ifdef CAP_DECIM_2X_EN
        keep_s = ~x_r[0] & ~y_r[0];
`else
        keep_s = 1'b1;
`endif
    end

    // Frame FSM and frame-skip counter; losing config_done abandons everything.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            skip_cnt_r <= {S_W{1'b0}};
        end else if (!bus.config_done) begin
            state_r    <= ST_IDLE;
            skip_cnt_r <= {S_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_WAIT_VS;
                end
                ST_WAIT_VS: begin
                    if (vs_fall_s) begin
                        state_r <= (skip_cnt_r == {S_W{1'b0}}) ? ST_ACTIVE : ST_SKIP;
                    end else begin
                        state_r <= ST_WAIT_VS;
                    end
                end
                ST_ACTIVE, ST_SKIP: begin
                    if (vs_rise_s) begin
                        state_r    <= ST_WAIT_VS;
                        skip_cnt_r <= (skip_cnt_r == S_W'(FRAME_SKIP)) ? {S_W{1'b0}}
                                                                       : skip_cnt_r + S_W'(1);
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // End-of-stored-frame pulse, one cycle after the closing vsync rise.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= bus.config_done & (state_r == ST_ACTIVE) & vs_rise_s;
        end
    end

    // Byte pairing, x/y tracking and running write address.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            phase_r    <= 1'b0;
            byte0_r    <= 8'h00;
            x_r        <= {X_W{1'b0}};
            y_r        <= {Y_W{1'b0}};
            line_pix_r <= 1'b0;
            addr_r     <= {ADDR_W{1'b0}};
            wr_pend_r  <= 1'b0;
            pix_r      <= {PIX_W{1'b0}};
            wr_addr_r  <= {ADDR_W{1'b0}};
        end else if (!in_frame_s) begin
            phase_r    <= 1'b0;
            x_r        <= {X_W{1'b0}};
            y_r        <= {Y_W{1'b0}};
            line_pix_r <= 1'b0;
            addr_r     <= {ADDR_W{1'b0}};
            wr_pend_r  <= 1'b0;
        end else begin
            wr_pend_r <= 1'b0;
            if (vs_edge_s) begin
                // vsync edge outranks any half-formed pair
                phase_r <= 1'b0;
            end else if (href_r) begin
                phase_r <= ~phase_r;
                if (!phase_r) begin
                    byte0_r <= data_r;
                end else begin
                    line_pix_r <= 1'b1;
                    x_r        <= (x_r == {X_W{1'b1}}) ? x_r : x_r + X_W'(1);
                    if ((state_r == ST_ACTIVE) && in_bounds_s && keep_s) begin
                        pix_r     <= fmt_pix(pix565_s);
                        wr_addr_r <= addr_r;
                        addr_r    <= addr_r + ADDR_W'(1);
                        wr_pend_r <= 1'b1;
                    end else begin
                        wr_pend_r <= 1'b0;
                    end
                end
            end else begin
                phase_r <= 1'b0;
                if (href_fall_s) begin
                    x_r        <= {X_W{1'b0}};
                    line_pix_r <= 1'b0;
                    if (line_pix_r && (y_r != {Y_W{1'b1}})) begin
                        y_r <= y_r + Y_W'(1);
                    end else begin
                        y_r <= y_r;
                    end
                end else begin
                    x_r <= x_r;
                end
            end
        end
    end

    // Sticky overflow: out-of-window pixel or dangling byte at line end.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            ovf_err_r <= 1'b0;
        end else if (in_frame_s && (state_r == ST_ACTIVE) && !vs_edge_s) begin
            if (pair_s && !in_bounds_s) begin
                ovf_err_r <= 1'b1;
            end else if (!href_r && href_fall_s && phase_r) begin
                ovf_err_r <= 1'b1;
            end else begin
                ovf_err_r <= ovf_err_r;
            end
        end else begin
            ovf_err_r <= ovf_err_r;
        end
    end

    // Registered RAM write port.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            data_en_r  <= 1'b0;
            rgb_data_r <= {PIX_W{1'b0}};
            ram_addr_r <= {ADDR_W{1'b0}};
        end else begin
            data_en_r <= wr_pend_r & bus.config_done;
            if (wr_pend_r) begin
                rgb_data_r <= pix_r;
                ram_addr_r <= wr_addr_r;
            end else begin
                rgb_data_r <= rgb_data_r;
                ram_addr_r <= ram_addr_r;
            end
        end
    end

    assign bus.data_en    = data_en_r;
    assign bus.rgb_data   = rgb_data_r;
    assign bus.RAM_addr   = ram_addr_r;
    assign bus.frame_done = frame_done_r;
    assign bus.ovf_err    = ovf_err_r;

endmodule

// File: tb/tb_cam_pix_capture_param.sv
// Randomized frame stimulus; expected writes queued by a line/pixel-level model, checked by a monitor.
module tb_cam_pix_capture_param;
    localparam int H    = 4;
    localparam int V    = 3;
    localparam int AW   = 4;
    localparam int PW   = 12;
    localparam int SKIP = 1;
    localparam int HF   = 1;

    typedef struct packed {
        logic [PW-1:0] rgb;
        logic [AW-1:0] addr;
    } exp_t;

    logic pclk = 1'b0;
    logic rst  = 1'b1;

    cam_pix_capture_param_if #(.ADDR_W(AW), .PIX_W(PW)) bus ();

    cam_pix_capture_param #(
        .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .PIX_W(PW),
        .FRAME_SKIP(SKIP), .HI_FIRST(HF)
    ) dut (
        .pclk(pclk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 pclk = ~pclk;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   fd_seen = 0;
    int   fd_exp = 0;
    bit   err_exp = 1'b0;
    int   chk_req = 0;
    int   chk_ack = 0;
    bit   prev_en = 1'b0;

    // model state
    int   fcnt = 0;
    bit   m_store = 1'b0;
    int   m_addr = 0;
    int   m_y = 0;
    bit   dropped = 1'b0;
    int   lens[8];

    function automatic logic [PW-1:0] exp_pix(input int b0, input int b1);
        int p;
        int r;
        int g;
        int b;
        p = (HF != 0) ? (b0 * 256 + b1) : (b1 * 256 + b0);
        if (PW == 16) return PW'(p);
        r = (p / 4096) % 16;
        g = (p / 128) % 16;
        b = (p / 2) % 16;
        return PW'(r * 256 + g * 16 + b);
    endfunction

    function automatic bit kept(input int x, input int y);
`ifdef CAP_DECIM_2X_EN
        return (x % 2 == 0) && (y % 2 == 0);
`else
        return 1'b1;
`endif
    endfunction

    // A completed byte pair at column x of the current line.
    task automatic model_pixel(input int b0, input int b1, input int x);
        exp_t e;
        if (m_store) begin
            if (x >= H || m_y >= V) begin
                err_exp = 1'b1;
            end else if (kept(x, m_y)) begin
                e.rgb  = exp_pix(b0, b1);
                e.addr = AW'(m_addr);
                exp_q.push_back(e);
                m_addr++;
            end
        end
    endtask

    // Monitor: reset values, write scoreboard, frame_done count, checkpoints.
    always @(negedge pclk) begin : mon
        exp_t e;
        if (rst) begin
            tests++;
            if (bus.data_en !== 1'b0 || bus.frame_done !== 1'b0 || bus.ovf_err !== 1'b0 ||
                bus.rgb_data !== '0 || bus.RAM_addr !== '0) begin
                fails++;
                $display("FAIL reset_outputs en=%b fd=%b err=%b rgb=%h addr=%0d required all 0",
                         bus.data_en, bus.frame_done, bus.ovf_err, bus.rgb_data, bus.RAM_addr);
            end
            prev_en = 1'b0;
        end else begin
            if (bus.frame_done) fd_seen++;
            if (bus.data_en) begin
                tests++;
                if (prev_en) begin
                    fails++;
                    $display("FAIL back_to_back data_en at t=%0t required gap", $time);
                end
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_write rgb=%h addr=%0d required no write",
                             bus.rgb_data, bus.RAM_addr);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.rgb_data !== e.rgb || bus.RAM_addr !== e.addr) begin
                        fails++;
                        $display("FAIL write_data rgb=%h addr=%0d required rgb=%h addr=%0d",
                                 bus.rgb_data, bus.RAM_addr, e.rgb, e.addr);
                    end
                end
            end
            prev_en = bus.data_en;
            if (chk_req != chk_ack) begin
                tests += 3;
                if (fd_seen != fd_exp) begin
                    fails++;
                    $display("FAIL frame_done_count got=%0d required=%0d", fd_seen, fd_exp);
                end
                if (bus.ovf_err !== err_exp) begin
                    fails++;
                    $display("FAIL ovf_err got=%b required=%b", bus.ovf_err, err_exp);
                end
                if (exp_q.size() != 0) begin
                    fails++;
                    $display("FAIL missing_writes got=%0d pending required=0", exp_q.size());
                end
                chk_ack = chk_req;
            end
        end
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic checkpoint();
        chk_req++;
        idle(2);
    endtask

    task automatic drive_line(input int nb, input bit fixed, input bit cut);
        int q[$];
        int b;
        for (int i = 0; i < nb; i++) begin
            if (fixed) b = (i % 2 == 0) ? 248 : 0;
            else       b = int'($urandom_range(0, 255));
            q.push_back(b);
            bus.href    = 1'b1;
            bus.data_in = 8'(b);
            if (cut && i == nb - 1) begin
                bus.vsync = 1'b1;
            end else if (i % 2 == 1) begin
                model_pixel(q[i - 1], q[i], i / 2);
            end
            tick();
        end
        bus.href    = 1'b0;
        bus.data_in = 8'($urandom_range(0, 255));
        if (m_store && (nb % 2 == 1)) err_exp = 1'b1;
        if (nb >= 2) m_y++;
        idle(2 + int'($urandom_range(0, 2)));
    endtask

    task automatic drop_config();
        bus.config_done = 1'b0;
        idle(2);
        bus.config_done = 1'b1;
        m_store = 1'b0;
        fcnt    = 0;
        dropped = 1'b1;
    endtask

    task automatic drive_frame(input int nlines, input bit fixed, input bit cut_last, input int drop_at);
        bus.vsync = 1'b1;
        idle(3);
        bus.vsync = 1'b0;
        m_store = ((fcnt % (SKIP + 1)) == 0);
        m_addr  = 0;
        m_y     = 0;
        dropped = 1'b0;
        idle(3);
        for (int l = 0; l < nlines; l++) begin
            if (l == drop_at) drop_config();
            drive_line(lens[l], fixed, cut_last && (l == nlines - 1));
        end
        bus.vsync = 1'b1;
        if (!dropped) begin
            if (m_store) fd_exp++;
            fcnt++;
        end
        idle(4);
        checkpoint();
    endtask

    task automatic rand_frame();
        int n;
        n = int'($urandom_range(1, V));
        for (int l = 0; l < 8; l++) lens[l] = 2 * int'($urandom_range(1, H));
        drive_frame(n, 1'b0, 1'b0, -1);
    endtask

    // Ensure the next frame is a stored one.
    task automatic align();
        if ((fcnt % (SKIP + 1)) != 0) rand_frame();
    endtask

    initial begin
        bus.config_done = 1'b0;
        bus.href        = 1'b0;
        bus.vsync       = 1'b0;
        bus.data_in     = 8'h00;
        idle(4);
        rst = 1'b0;
        idle(2);
        checkpoint();
        bus.config_done = 1'b1;
        idle(2);

        // two full lines of 0xF8,0x00: 8 writes of 0xF00 at 0..7, short frame
        for (int l = 0; l < 8; l++) lens[l] = 2 * H;
        drive_frame(2, 1'b1, 1'b0, -1);
        for (int f = 0; f < 9; f++) rand_frame();

        // 5-pixel line, 7-byte line
        align();
        lens[0] = 10; lens[1] = 7; lens[2] = 8;
        drive_frame(3, 1'b0, 1'b0, -1);
        for (int f = 0; f < 2; f++) rand_frame();

        // one line more than V_ACTIVE
        align();
        for (int l = 0; l < 8; l++) lens[l] = 2 * H;
        drive_frame(V + 1, 1'b0, 1'b0, -1);

        // vsync rise on the last byte of a pair
        align();
        for (int l = 0; l < 8; l++) lens[l] = 2 * H;
        drive_frame(2, 1'b0, 1'b1, -1);

        // config_done dropped after first line, then restart
        align();
        drive_frame(3, 1'b0, 1'b0, 1);
        rand_frame();
        rand_frame();

        // reset mid-line with data toggling, capture idle
        bus.config_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.href    = 1'b1;
            bus.data_in = 8'($urandom_range(0, 255));
            tick();
        end
        @(posedge pclk);
        #3;
        rst = 1'b1;
        err_exp = 1'b0;
        m_store = 1'b0;
        fcnt = 0;
        idle(3);
        rst = 1'b0;
        bus.config_done = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.data_in = 8'($urandom_range(0, 255));
            tick();
        end
        bus.href = 1'b0;
        idle(3);
        checkpoint();
        for (int f = 0; f < 4; f++) rand_frame();

        idle(4);
        checkpoint();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
